// File: rtl/mem_io_responder_pkg.sv
// Shared types and IO-window addresses for the memory/IO responder.
package mem_io_pkg;

  typedef logic [7:0] byte_t;

  localparam logic [1:0]  IO_BASE      = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  function automatic byte_t word_byte(input logic [31:0] word, input logic [1:0] sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide core memory bus: the core drives address/data/strobe, the responder returns read data and flow control.
interface mem_io_responder_if;
  import mem_io_pkg::*;

  logic [31:0] mem_a;
  byte_t       mem_dout;
  logic        mem_wr;
  byte_t       mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_dout, mem_wr,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    output mem_din, io_buffer_full
  );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Power-of-two byte FIFO with extra-MSB pointers; a pop in the same cycle frees the slot for a push when full.
module byte_fifo
  import mem_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  byte_t                  push_data,
  input  logic                   pop,
  output byte_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic          push_ok, pop_ok;
  byte_t         store [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign wr_ptr_next = push_ok ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_ptr_next = pop_ok  ? rd_ptr + PW'(1) : rd_ptr;

  assign head       = store[rd_ptr[AW-1:0]];
  assign count      = wr_ptr - rd_ptr;
  assign count_next = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target-side responder for the core's byte bus: RAM plus IO window (UART FIFOs, cycle counter, program stop).
// Optional macro CYCLE_SNAPSHOT_EN: a byte-0 counter read latches the counter so bytes 1..3 come from the same value.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8,
  parameter int RX_FIFO_DEPTH  = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  mem_io_responder_if.slave bus,
  output byte_t             tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  byte_t             rx_data,
  input  logic              rx_valid,
  output logic              sim_done,
  output logic              tx_overflow
);

  localparam int TX_CW = $clog2(TX_FIFO_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_FIFO_DEPTH) + 1;
  localparam logic [TX_CW-1:0] TX_ALMOST_FULL = TX_CW'(TX_FIFO_DEPTH - 1);

  logic [17:0]               addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      io, uart_sel, stop_sel, clk_sel;
  logic                      unused_addr_hi;

  assign addr           = bus.mem_a[17:0];
  assign ram_idx        = bus.mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^bus.mem_a[31:18];
  assign io             = (addr[17:16] == IO_BASE);
  assign uart_sel       = (addr == IO_UART_ADDR);
  assign stop_sel       = (addr == IO_CLK_ADDR);
  assign clk_sel        = (addr[17:2] == IO_CLK_ADDR[17:2]);

  byte_t ram [2**RAM_ADDR_WIDTH];

  always_ff @(posedge clk_in) begin
    if (bus.mem_wr && !io) begin
      ram[ram_idx] <= bus.mem_dout;
    end
  end

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  byte_t                tx_push_data;
  logic [TX_CW-1:0]     tx_unused_count, tx_count_next;

  // The stop write pushes a 0x00 marker that the zero filter on the UART address would otherwise discard.
  assign tx_push      = bus.mem_wr && ((uart_sel && bus.mem_dout != 8'h00) || stop_sel);
  assign tx_push_data = stop_sel ? 8'h00 : bus.mem_dout;
  assign tx_valid     = !tx_empty;
  assign tx_pop       = tx_valid && tx_ready;

  byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_unused_count),
    .count_next(tx_count_next)
  );

  logic             rx_pop, rx_empty, rx_unused_full;
  byte_t            rx_head;
  logic [RX_CW-1:0] rx_unused_count, rx_unused_count_next;

  assign rx_pop = !bus.mem_wr && uart_sel && !rx_empty;

  byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_unused_full),
    .empty     (rx_empty),
    .count     (rx_unused_count),
    .count_next(rx_unused_count_next)
  );

  logic [31:0] cycle_count;
  logic [31:0] clk_src;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

`ifdef CYCLE_SNAPSHOT_EN
  logic [31:0] snapshot;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      snapshot <= '0;
    end else if (!bus.mem_wr && clk_sel && addr[1:0] == 2'b00) begin
      snapshot <= cycle_count;
    end
  end

  assign clk_src = (addr[1:0] == 2'b00) ? cycle_count : snapshot;
`else
  assign clk_src = cycle_count;
`endif

  byte_t io_rd_data;

  always_comb begin
    io_rd_data = 8'h00;
    if (uart_sel) begin
      io_rd_data = rx_empty ? 8'h00 : rx_head;
    end else if (clk_sel) begin
      io_rd_data = word_byte(clk_src, addr[1:0]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.mem_din <= 8'h00;
    end else if (!bus.mem_wr) begin
      bus.mem_din <= io ? io_rd_data : ram[ram_idx];
    end
  end

  // Almost-full leaves one slot for the write the core may already have in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.io_buffer_full <= 1'b0;
      sim_done           <= 1'b0;
      tx_overflow        <= 1'b0;
    end else begin
      bus.io_buffer_full <= (tx_count_next >= TX_ALMOST_FULL);
      if (bus.mem_wr && stop_sel) begin
        sim_done <= 1'b1;
      end
      if (tx_push && tx_full && !tx_pop) begin
        tx_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed bus/UART traffic, read data and TX bytes checked by a monitor.
module tb_mem_io_responder;
  import mem_io_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  tx_ready = 1'b0;
  logic  rx_valid = 1'b0;
  byte_t rx_data = 8'h00;
  byte_t tx_data;
  logic  tx_valid, sim_done, tx_overflow;

  always #5 clk = ~clk;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .bus        (bus),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .sim_done   (sim_done),
    .tx_overflow(tx_overflow)
  );

  int          checks = 0;
  int          errors = 0;
  byte_t       rd_q[$];
  byte_t       tx_q[$];
  byte_t       exp_b;
  logic        rd_chk = 1'b0;
  logic        rd_cap;
  int unsigned edges;
  byte_t       clk_bytes [4] = '{8'h34, 8'h12, 8'h00, 8'h00};

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Marks which edges capture a read whose data the monitor must check.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges  <= 0;
      rd_cap <= 1'b0;
    end else begin
      edges  <= edges + 1;
      rd_cap <= rd_chk;
    end
  end

  always @(negedge clk) begin
    if (rd_cap) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rd_unexpected: got 0x%0h, expected no read", bus.mem_din);
      end else begin
        exp_b = rd_q.pop_front();
        check_output("mem_din", bus.mem_din, exp_b);
      end
    end
    if (rst_n && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
      end else begin
        exp_b = tx_q.pop_front();
        check_output("tx_data", tx_data, exp_b);
      end
    end
  end

  // One bus transaction; the bus falls back to an unchecked read of address 0 afterwards.
  task automatic apply_stimulus(input logic [31:0] a, input logic wr, input byte_t d,
                                input logic chk, input byte_t exp_rd);
    bus.mem_a    = a;
    bus.mem_wr   = wr;
    bus.mem_dout = d;
    rd_chk       = chk;
    if (chk) rd_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    bus.mem_a    = 32'h0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
    rd_chk       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic rx_push(input byte_t d);
    rx_data  = d;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.mem_a    = 32'h0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_mem_din", bus.mem_din, 8'h00);
    check_output("reset_sim_done", sim_done, 1'b0);
    check_output("reset_tx_overflow", tx_overflow, 1'b0);
    check_output("reset_tx_valid", tx_valid, 1'b0);
    check_output("reset_io_buffer_full", bus.io_buffer_full, 1'b0);
    rst_n = 1'b1;

    $display("[TB] cycle counter");
    while (edges != 32'h1234) idle(1);
    for (int i = 0; i < 4; i++) apply_stimulus(32'h30004 + i, 1'b0, 8'h00, 1'b1, clk_bytes[i]);

    $display("[TB] RAM round trip");
    apply_stimulus(32'h00010, 1'b1, 8'hA5, 1'b0, 8'h00);
    apply_stimulus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5);
    apply_stimulus(32'h1FFFF, 1'b1, 8'h3C, 1'b0, 8'h00);
    apply_stimulus(32'h1FFFF, 1'b0, 8'h00, 1'b1, 8'h3C);

    $display("[TB] UART TX with zero filter");
    tx_ready = 1'b1;
    tx_q.push_back(8'h48);
    tx_q.push_back(8'h69);
    apply_stimulus(32'h30000, 1'b1, 8'h48, 1'b0, 8'h00);
    apply_stimulus(32'h30000, 1'b1, 8'h00, 1'b0, 8'h00);
    apply_stimulus(32'h30000, 1'b1, 8'h69, 1'b0, 8'h00);
    idle(3);
    check_output("tx_drain_basic", tx_q.size(), 0);

    $display("[TB] TX backpressure");
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      apply_stimulus(32'h30000, 1'b1, 8'h41 + 8'(i), 1'b0, 8'h00);
      if (i == 5) check_output("ibf_at_6", bus.io_buffer_full, 1'b0);
      if (i == 6) check_output("ibf_at_7", bus.io_buffer_full, 1'b1);
    end
    check_output("no_overflow_at_8", tx_overflow, 1'b0);
    apply_stimulus(32'h30000, 1'b1, 8'h49, 1'b0, 8'h00);
    check_output("overflow_at_9", tx_overflow, 1'b1);
    check_output("ibf_full", bus.io_buffer_full, 1'b1);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    check_output("ibf_after_one_pop", bus.io_buffer_full, 1'b1);
    check_output("tx_q_after_one_pop", tx_q.size(), 7);
    tx_ready = 1'b1;
    idle(10);
    check_output("tx_valid_drained", tx_valid, 1'b0);
    check_output("ibf_drained", bus.io_buffer_full, 1'b0);
    check_output("tx_drain_full", tx_q.size(), 0);

    $display("[TB] RX FIFO");
    rx_push(8'h31);
    rx_push(8'h32);
    apply_stimulus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h31);
    apply_stimulus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h32);
    apply_stimulus(32'h30000, 1'b0, 8'h00, 1'b1, 8'h00);

    $display("[TB] unmapped IO and program stop");
    apply_stimulus(32'h30008, 1'b1, 8'h55, 1'b0, 8'h00);
    apply_stimulus(32'h30008, 1'b0, 8'h00, 1'b1, 8'h00);
    check_output("sim_done_before_stop", sim_done, 1'b0);
    tx_q.push_back(8'h00);
    apply_stimulus(32'h30004, 1'b1, 8'h77, 1'b0, 8'h00);
    check_output("sim_done_set", sim_done, 1'b1);
    idle(3);
    check_output("tx_drain_stop", tx_q.size(), 0);

    $display("[TB] asynchronous reset mid-burst");
    tx_ready = 1'b0;
    apply_stimulus(32'h30000, 1'b1, 8'h61, 1'b0, 8'h00);
    apply_stimulus(32'h30000, 1'b1, 8'h62, 1'b0, 8'h00);
    check_output("tx_valid_before_reset", tx_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_sim_done", sim_done, 1'b0);
    check_output("async_tx_valid", tx_valid, 1'b0);
    check_output("async_tx_overflow", tx_overflow, 1'b0);
    check_output("async_mem_din", bus.mem_din, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(32'h30004, 1'b0, 8'h00, 1'b1, 8'h00);
    apply_stimulus(32'h00010, 1'b0, 8'h00, 1'b1, 8'hA5);
    idle(2);
    check_output("rd_queue_empty", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
